// File: rtl/ame_num_log2_pipe.sv
// Three-stage multi-lane approximate log2: |x| and flags, leading-one detect, then pack
// floor / round / Mitchell result. Elastic valid/ready pipeline with synchronous flush.
module ame_num_log2_pipe #(
  parameter int unsigned DATA_BITS = 64,
  parameter int unsigned LANES     = 4,
  parameter int unsigned FRAC_BITS = 4,
  parameter int unsigned TAG_BITS  = 8,
  localparam int unsigned LOG_BITS = $clog2(DATA_BITS) + 1
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic                                     flush_i,
  input  logic                                     in_valid_i,
  output logic                                     in_ready_o,
  input  logic [1:0]                               in_mode_i,
  input  logic [TAG_BITS-1:0]                      in_tag_i,
  input  logic [LANES*DATA_BITS-1:0]               in_data_i,
  output logic                                     out_valid_o,
  input  logic                                     out_ready_i,
  output logic [TAG_BITS-1:0]                      out_tag_o,
  output logic [LANES-1:0]                         out_sign_o,
  output logic [LANES-1:0]                         out_zero_o,
  output logic [LANES*(LOG_BITS+FRAC_BITS)-1:0]    out_log_o
);

  localparam int unsigned EW = LOG_BITS - 1;
  localparam int unsigned FW = (FRAC_BITS > 0) ? FRAC_BITS : 1;
  localparam int unsigned LW = LOG_BITS + FRAC_BITS;

  logic v1_q, v2_q, v3_q;
  logic rdy1, rdy2, rdy3;

  assign rdy3       = !v3_q || out_ready_i;
  assign rdy2       = !v2_q || rdy3;
  assign rdy1       = !v1_q || rdy2;
  assign in_ready_o = rdy1;

  // Stage 1 state
  logic [LANES-1:0][DATA_BITS-1:0] abs1_d, abs1_q;
  logic [LANES-1:0]                sign1_d, sign1_q, zero1_d, zero1_q;
  logic [1:0]                      mode1_q;
  logic [TAG_BITS-1:0]             tag1_q;

  // Stage 2 state
  logic [LANES-1:0][EW-1:0]        e2_d, e2_q;
  logic [LANES-1:0]                r2_d, r2_q;
  logic [LANES-1:0][FW-1:0]        frac2_d, frac2_q;
  logic [LANES-1:0]                sign2_q, zero2_q;
  logic [1:0]                      mode2_q;
  logic [TAG_BITS-1:0]             tag2_q;

  // Stage 3 (output) state
  logic [LANES-1:0][LOG_BITS-1:0]  log_int_d;
  logic [LANES-1:0][FW-1:0]        log_frac_d;
  logic [LANES*LW-1:0]             log3_d, log3_q;
  logic [LANES-1:0]                sign3_q, zero3_q;
  logic [TAG_BITS-1:0]             tag3_q;

  // Unsigned negate so the most negative value maps onto 2^(N-1).
  always_comb begin
    abs1_d  = '0;
    sign1_d = '0;
    zero1_d = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      sign1_d[k] = in_data_i[k*DATA_BITS + DATA_BITS - 1];
      zero1_d[k] = (in_data_i[k*DATA_BITS +: DATA_BITS] == '0);
      abs1_d[k]  = sign1_d[k] ? -in_data_i[k*DATA_BITS +: DATA_BITS]
                              : in_data_i[k*DATA_BITS +: DATA_BITS];
    end
  end

  always_comb begin
    e2_d    = '0;
    r2_d    = '0;
    frac2_d = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      for (int unsigned i = 0; i < DATA_BITS; i++) begin
        if (abs1_q[k][i]) e2_d[k] = EW'(i);
      end
      if (e2_d[k] != '0) r2_d[k] = abs1_q[k][e2_d[k] - EW'(1)];
      // Bits below the leading one, MSB-first; positions below bit 0 read as zero.
      for (int unsigned i = 0; i < FW; i++) begin
        if (e2_d[k] > EW'(i)) frac2_d[k][FW-1-i] = abs1_q[k][e2_d[k] - EW'(i + 1)];
      end
    end
  end

  always_comb begin
    log_int_d  = '0;
    log_frac_d = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (!zero2_q[k]) begin
        log_int_d[k] = {1'b0, e2_q[k]};
        if (mode2_q == 2'd1) log_int_d[k] = {1'b0, e2_q[k]} + {{EW{1'b0}}, r2_q[k]};
        if (mode2_q == 2'd2) log_frac_d[k] = frac2_q[k];
      end
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_pack
    if (FRAC_BITS > 0) begin : g_frac
      assign log3_d[k*LW +: LW] = {log_int_d[k], log_frac_d[k][FRAC_BITS-1:0]};
    end else begin : g_nofrac
      assign log3_d[k*LW +: LW] = log_int_d[k];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      abs1_q  <= '0;
      sign1_q <= '0;
      zero1_q <= '0;
      mode1_q <= '0;
      tag1_q  <= '0;
      e2_q    <= '0;
      r2_q    <= '0;
      frac2_q <= '0;
      sign2_q <= '0;
      zero2_q <= '0;
      mode2_q <= '0;
      tag2_q  <= '0;
      log3_q  <= '0;
      sign3_q <= '0;
      zero3_q <= '0;
      tag3_q  <= '0;
    end else if (flush_i) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else begin
      if (rdy1) begin
        v1_q <= in_valid_i;
        if (in_valid_i) begin
          abs1_q  <= abs1_d;
          sign1_q <= sign1_d;
          zero1_q <= zero1_d;
          mode1_q <= in_mode_i;
          tag1_q  <= in_tag_i;
        end
      end
      if (rdy2) begin
        v2_q <= v1_q;
        if (v1_q) begin
          e2_q    <= e2_d;
          r2_q    <= r2_d;
          frac2_q <= frac2_d;
          sign2_q <= sign1_q;
          zero2_q <= zero1_q;
          mode2_q <= mode1_q;
          tag2_q  <= tag1_q;
        end
      end
      // Payload only moves on a real hand-off, so it holds while stalled.
      if (rdy3) begin
        v3_q <= v2_q;
        if (v2_q) begin
          log3_q  <= log3_d;
          sign3_q <= sign2_q;
          zero3_q <= zero2_q;
          tag3_q  <= tag2_q;
        end
      end
    end
  end

  assign out_valid_o = v3_q;
  assign out_tag_o   = tag3_q;
  assign out_sign_o  = sign3_q;
  assign out_zero_o  = zero3_q;
  assign out_log_o   = log3_q;

endmodule

// File: tb/tb_ame_num_log2_pipe.sv
// Self-checking bench for ame_num_log2_pipe: directed corner cases plus randomized traffic
// scored against an arithmetic log2 reference model.
module tb_ame_num_log2_pipe;

  localparam int DB   = 64;
  localparam int LN   = 4;
  localparam int FB   = 4;
  localparam int TAGW = 8;
  localparam int LB   = $clog2(DB) + 1;
  localparam int LW   = LB + FB;
  localparam int PW   = TAGW + 2 * LN + LN * LW;

  logic              clk, rst_i, flush_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i;
  logic [1:0]        in_mode_i;
  logic [TAGW-1:0]   in_tag_i, out_tag_o;
  logic [LN*DB-1:0]  in_data_i;
  logic [LN-1:0]     out_sign_o, out_zero_o;
  logic [LN*LW-1:0]  out_log_o;

  ame_num_log2_pipe #(
    .DATA_BITS(DB), .LANES(LN), .FRAC_BITS(FB), .TAG_BITS(TAGW)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_mode_i(in_mode_i),
    .in_tag_i(in_tag_i), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_tag_o(out_tag_o),
    .out_sign_o(out_sign_o), .out_zero_o(out_zero_o), .out_log_o(out_log_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [TAGW-1:0]  tag;
    logic [LN-1:0]    sign;
    logic [LN-1:0]    zero;
    logic [LN*LW-1:0] log;
  } exp_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  logic        s_acc, s_in_ready, s_out_valid, stall_q;
  logic [PW-1:0] held;
  logic [TAGW-1:0] ntag;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: floor log2 by repeated halving; round by comparing against 1.5*2^e;
  // Mitchell fraction as the scaled mantissa (|x|-2^e)/2^e truncated to FB bits.
  function automatic exp_t model(input logic [1:0] mode, input logic [TAGW-1:0] tag,
                                 input logic [LN*DB-1:0] d);
    exp_t          r;
    logic [DB-1:0] x, a;
    logic [127:0]  w, p;
    logic [LB-1:0] iv;
    logic [FB-1:0] fv;
    int            e;
    r.tag  = tag;
    r.sign = '0;
    r.zero = '0;
    r.log  = '0;
    for (int k = 0; k < LN; k++) begin
      x = d[k*DB +: DB];
      r.sign[k] = x[DB-1];
      a = x[DB-1] ? DB'(0) - x : x;
      r.zero[k] = (a == '0);
      iv = '0;
      fv = '0;
      if (a != '0) begin
        e = 0;
        w = 128'(a);
        while (w > 128'd1) begin
          w = w >> 1;
          e++;
        end
        p = 128'd1 << e;
        case (mode)
          2'd1: iv = (128'd2 * 128'(a) >= 128'd3 * p) ? LB'(e + 1) : LB'(e);
          2'd2: begin
            iv = LB'(e);
            w  = ((128'(a) - p) << FB) >> e;
            fv = w[FB-1:0];
          end
          default: iv = LB'(e);
        endcase
      end
      r.log[k*LW +: LW] = {iv, fv};
    end
    return r;
  endfunction

  function automatic logic [DB-1:0] rnd_lane();
    logic [DB-1:0] v;
    v = {$urandom, $urandom};
    case ($urandom_range(0, 5))
      0: v = '0;
      1: v = {1'b1, {(DB - 1){1'b0}}};
      2: v = DB'(1) << $urandom_range(0, DB - 1);
      3: v = DB'(0) - DB'($urandom_range(1, 20));
      4: v = v >> $urandom_range(0, DB - 1);
      default: ;
    endcase
    return v;
  endfunction

  function automatic logic [LN*DB-1:0] mk(input logic [DB-1:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  // Evaluate this cycle's handshakes (inputs already driven), then move to the next negedge.
  task automatic step();
    exp_t e;
    #1;
    s_in_ready  = in_ready_o;
    s_out_valid = out_valid_o;
    if (stall_q) check("hold", 256'({out_tag_o, out_sign_o, out_zero_o, out_log_o}), 256'(held));
    if (out_valid_o && out_ready_i) begin
      if (q.size() == 0) begin
        check("extra_out", 256'(out_tag_o) | 256'(1) << 200, 256'(0));
      end else begin
        e = q.pop_front();
        check("out_tag", 256'(out_tag_o), 256'(e.tag));
        check("out_sign", 256'(out_sign_o), 256'(e.sign));
        check("out_zero", 256'(out_zero_o), 256'(e.zero));
        check("out_log", 256'(out_log_o), 256'(e.log));
      end
    end
    s_acc = in_valid_i && in_ready_o && !flush_i;
    if (flush_i) q.delete();
    if (s_acc) q.push_back(model(in_mode_i, in_tag_i, in_data_i));
    stall_q = out_valid_o && !out_ready_i && !flush_i;
    held    = {out_tag_o, out_sign_o, out_zero_o, out_log_o};
    @(negedge clk);
  endtask

  task automatic send(input logic [1:0] mode, input logic [LN*DB-1:0] data);
    bit done = 0;
    in_valid_i = 1'b1;
    in_mode_i  = mode;
    in_tag_i   = ntag;
    in_data_i  = data;
    for (int i = 0; i < 20 && !done; i++) begin
      step();
      done = s_acc;
    end
    if (!done) check("accept_timeout", 256'(0), 256'(1));
    ntag++;
    in_valid_i = 1'b0;
  endtask

  // One transaction through an empty, unstalled pipe; checks 3-cycle latency and one lane.
  task automatic single(input string name, input logic [1:0] mode, input logic [LN*DB-1:0] data,
                        input int lane, input logic [LB-1:0] ei, input logic [FB-1:0] ef,
                        input logic es, input logic ez);
    logic [LW-1:0] lv;
    out_ready_i = 1'b1;
    in_valid_i  = 1'b1;
    in_mode_i   = mode;
    in_tag_i    = ntag;
    in_data_i   = data;
    step();
    check({name, "_acc"}, 256'(s_acc), 256'(1));
    in_valid_i = 1'b0;
    ntag++;
    step();
    check({name, "_early1"}, 256'(s_out_valid), 256'(0));
    step();
    check({name, "_early2"}, 256'(s_out_valid), 256'(0));
    lv = out_log_o[lane*LW +: LW];
    check({name, "_valid"}, 256'(out_valid_o), 256'(1));
    check({name, "_int"}, 256'(lv[LW-1:FB]), 256'(ei));
    check({name, "_frac"}, 256'(lv[FB-1:0]), 256'(ef));
    check({name, "_sign"}, 256'(out_sign_o[lane]), 256'(es));
    check({name, "_zero"}, 256'(out_zero_o[lane]), 256'(ez));
    step();
  endtask

  initial begin
    int acc;
    rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    in_mode_i = '0; in_tag_i = '0; in_data_i = '0; stall_q = 1'b0; ntag = 8'd1;
    #3;
    check("rst_valid", 256'(out_valid_o), 256'(0));
    check("rst_payload", 256'({out_tag_o, out_sign_o, out_zero_o, out_log_o}), 256'(0));
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    #1 check("rst_ready", 256'(in_ready_o), 256'(1));

    single("zero", 2'd0, mk(0, 5, 0, 0), 0, 0, 0, 1'b0, 1'b1);
    single("m96_floor", 2'd0, mk(-64'sd96, 0, 0, 0), 0, 6, 0, 1'b1, 1'b0);
    single("m96_round", 2'd1, mk(-64'sd96, 0, 0, 0), 0, 7, 0, 1'b1, 1'b0);
    single("m96_mitch", 2'd2, mk(-64'sd96, 0, 0, 0), 0, 6, 4'b1000, 1'b1, 1'b0);
    single("min_round", 2'd1, mk(0, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1),
           1, 63, 0, 1'b1, 1'b0);
    single("max_round", 2'd1, mk(0, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1),
           2, 63, 0, 1'b0, 1'b0);
    single("one_round", 2'd1, mk(0, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1),
           3, 0, 0, 1'b0, 1'b0);
    single("three_round", 2'd1, mk(0, 0, 0, 3), 3, 2, 0, 1'b0, 1'b0);

    // Backpressure: six back-to-back offers against a stalled sink.
    ntag = 8'd1;
    out_ready_i = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_valid_i = 1'b1;
      in_mode_i  = 2'($urandom);
      in_tag_i   = ntag;
      in_data_i  = mk(rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane());
      step();
      check("bp_ready", 256'(s_in_ready), 256'(c < 3));
      if (s_acc) ntag++;
    end
    out_ready_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      in_valid_i = (ntag <= 8'd6);
      in_mode_i  = 2'($urandom);
      in_tag_i   = ntag;
      in_data_i  = mk(rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane());
      step();
      check("bp_nogap", 256'(s_out_valid), 256'(1));
      if (s_acc) ntag++;
    end
    in_valid_i = 1'b0;
    check("bp_drained", 256'(q.size()), 256'(0));

    // Random traffic.
    acc = 0;
    for (int c = 0; c < 40000 && acc < 10000; c++) begin
      in_valid_i  = ($urandom_range(0, 3) != 0);
      out_ready_i = ($urandom_range(0, 9) < 7);
      in_mode_i   = 2'($urandom);
      in_tag_i    = 8'($urandom);
      in_data_i   = mk(rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane());
      step();
      if (s_acc) acc++;
    end
    check("rand_count", 256'(acc), 256'(10000));
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    for (int c = 0; c < 10 && q.size() != 0; c++) step();
    check("rand_drained", 256'(q.size()), 256'(0));

    // Flush with three in flight, plus an offer in the flush cycle.
    out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) send(2'd1, mk(rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane()));
    flush_i    = 1'b1;
    in_valid_i = 1'b1;
    in_data_i  = mk(7, 7, 7, 7);
    step();
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    check("flush_valid", 256'(out_valid_o), 256'(0));
    single("post_flush", 2'd2, mk(64'd200, 0, 0, 0), 0, 7, 4'b1001, 1'b0, 1'b0);

    // Asynchronous reset between edges with the pipe full.
    out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) send(2'd0, mk(rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane()));
    #3 rst_i = 1'b1;
    #1;
    check("arst_valid", 256'(out_valid_o), 256'(0));
    check("arst_payload", 256'({out_tag_o, out_sign_o, out_zero_o, out_log_o}), 256'(0));
    q.delete();
    stall_q = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
    #1 check("arst_ready", 256'(in_ready_o), 256'(1));
    single("post_rst", 2'd1, mk(0, 0, 0, -64'sd5), 3, 2, 0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
